// File: rtl/led_app_dispatcher.sv
// Key debouncer plus menu FSM that launches one of N_APPS sub-modules and muxes its frame onto the LED matrix.
// All outputs are registered; led follows state/inputs with one cycle of latency and there is no backpressure.
module led_app_dispatcher #(
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int N_APPS       = 4,
  parameter int N_KEYS       = 9,
  parameter int DEBOUNCE_CYC = 50000,
  localparam int SW          = (N_APPS > 1) ? $clog2(N_APPS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_KEYS-1:0]           keys,
  input  logic [N_APPS*ROWS*COLS-1:0] app_led,
  input  logic [N_APPS-1:0]           app_done,
  output logic [N_APPS-1:0]           app_en,
  output logic [N_KEYS-1:0]           app_keys,
  output logic [ROWS*COLS-1:0]        led,
  output logic [SW-1:0]               sel_idx,
  output logic                        busy
);

  localparam int FW = ROWS * COLS;
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {MENU, LAUNCH, RUN, EXIT} state_e;

  logic [N_KEYS-1:0] sync1_q, sync2_q, lvl_q, press_q;
  logic [CW-1:0]     cnt_q [N_KEYS];

  // A key's accepted level flips only once the synchronised level has differed for DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      for (int k = 0; k < N_KEYS; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        if (sync2_q[k] == lvl_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CW'(DEBOUNCE_CYC - 1)) begin
          lvl_q[k]   <= sync2_q[k];
          press_q[k] <= sync2_q[k];
          cnt_q[k]   <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  state_e            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [N_APPS-1:0] app_en_q, onehot;
  logic [N_KEYS-1:0] app_keys_q;
  logic [FW-1:0]     led_q, menu_frame;
  logic              busy_q, running;

  wire prev_p = press_q[0];
  wire next_p = press_q[1];
  wire sel_p  = press_q[2];
  wire esc_p  = press_q[N_KEYS-1];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      MENU: begin
        if (sel_p) begin
          state_d = LAUNCH;
        end else if (next_p && !prev_p) begin
          sel_d = (sel_q == SW'(N_APPS - 1)) ? '0 : sel_q + 1'b1;
        end else if (prev_p && !next_p) begin
          sel_d = (sel_q == '0) ? SW'(N_APPS - 1) : sel_q - 1'b1;
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        if (app_done[sel_q] || esc_p) state_d = EXIT;
      end
      default: state_d = MENU;
    endcase
  end

  always_comb begin
    onehot        = '0;
    onehot[sel_q] = 1'b1;
  end

  // Menu picture: highlighted row fully lit, column 0 marks every row that has an app behind it.
  always_comb begin
    menu_frame = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r == int'(sel_q) || (c == 0 && r < N_APPS)) menu_frame[r*COLS + c] = 1'b1;
      end
    end
  end

  assign running = (state_q == LAUNCH) || (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MENU;
      sel_q      <= '0;
      app_en_q   <= '0;
      app_keys_q <= '0;
      busy_q     <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      app_en_q   <= running ? onehot : '0;
      app_keys_q <= running ? lvl_q : '0;
      busy_q     <= running;
      case (state_q)
        MENU:        led_q <= menu_frame;
        LAUNCH, RUN: led_q <= app_led[int'(sel_q)*FW +: FW];
        default:     led_q <= '0;
      endcase
    end
  end

  assign app_en   = app_en_q;
  assign app_keys = app_keys_q;
  assign busy     = busy_q;
  assign led      = led_q;
  assign sel_idx  = sel_q;

endmodule

// File: tb/tb_led_app_dispatcher.sv
// Directed bench for led_app_dispatcher: menu navigation, launch, return paths and reset, 16x16 matrix, 4 apps.
module tb_led_app_dispatcher;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int NA   = 4;
  localparam int NK   = 9;
  localparam int DEB  = 4;
  localparam int FW   = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst;
  logic [NK-1:0]    keys;
  logic [NA*FW-1:0] app_led;
  logic [NA-1:0]    app_done;
  logic [NA-1:0]    app_en;
  logic [NK-1:0]    app_keys;
  logic [FW-1:0]    led;
  logic [1:0]       sel_idx;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Hand-built menu pictures: row s all ones, col 0 set in rows 0..3.
  localparam logic [FW-1:0] MENU0 = {192'b0, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
  localparam logic [FW-1:0] MENU2 = {192'b0, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001};

  led_app_dispatcher #(
    .ROWS(ROWS), .COLS(COLS), .N_APPS(NA), .N_KEYS(NK), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk), .rst(rst), .keys(keys), .app_led(app_led), .app_done(app_done),
    .app_en(app_en), .app_keys(app_keys), .led(led), .sel_idx(sel_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [NK-1:0] m, input int hold);
    keys = m;
    cycles(hold);
    keys = '0;
    cycles(12);
  endtask

  // Holds select until the app is enabled or the budget runs out; caller checks app_en.
  task automatic launch();
    keys = 9'h004;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      if (app_en !== 4'b0000) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; keys = '0; app_done = '0;
    cycles(3);
    checks++; if (app_en !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL reset_en: app_en=%b busy=%b, want 0000/0", app_en, busy); end
    checks++; if (led !== '0) begin errors++; $display("FAIL reset_led: led=%h, want 0", led); end
    rst = 1'b0;
    cycles(10);
    checks++; if (sel_idx !== 2'd0) begin errors++; $display("FAIL idle_sel: sel_idx=%0d, want 0", sel_idx); end
    checks++; if (led !== MENU0) begin errors++; $display("FAIL idle_led: led=%h, want %h", led, MENU0); end
    checks++; if (app_en !== 4'b0000 || app_keys !== '0) begin errors++; $display("FAIL idle_en: app_en=%b app_keys=%b, want 0", app_en, app_keys); end
  endtask

  task automatic test_nav();
    keys = 9'h002; cycles(3);
    keys = 9'h000; cycles(1);
    keys = 9'h002; cycles(10);
    checks++; if (app_keys !== '0) begin errors++; $display("FAIL menu_keys_hidden: app_keys=%b, want 0", app_keys); end
    keys = '0; cycles(12);
    checks++; if (sel_idx !== 2'd1) begin errors++; $display("FAIL glitch_next: sel_idx=%0d, want 1", sel_idx); end
    press(9'h001, 6);
    press(9'h001, 6);
    checks++; if (sel_idx !== 2'd3) begin errors++; $display("FAIL prev_wrap: sel_idx=%0d, want 3", sel_idx); end
    press(9'h001, 6);
    checks++; if (sel_idx !== 2'd2) begin errors++; $display("FAIL prev_to2: sel_idx=%0d, want 2", sel_idx); end
    checks++; if (led !== MENU2) begin errors++; $display("FAIL menu_led2: led=%h, want %h", led, MENU2); end
  endtask

  task automatic test_launch();
    logic [FW-1:0] exp;
    exp = app_led[2*FW +: FW];
    launch();
    checks++; if (app_en !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL launch_en: app_en=%b busy=%b, want 0100/1", app_en, busy); end
    checks++; if (led !== exp) begin errors++; $display("FAIL launch_led: led=%h, want %h", led, exp); end
    keys = '0; cycles(12);
    keys = 9'h020; cycles(10);
    checks++; if (app_keys !== 9'h020) begin errors++; $display("FAIL app_keys5: app_keys=%b, want 000100000", app_keys); end
    keys = '0; cycles(12);
    checks++; if (app_keys !== 9'h000) begin errors++; $display("FAIL app_keys_rel: app_keys=%b, want 0", app_keys); end
  endtask

  task automatic test_done();
    app_done = 4'b0010; cycles(1);
    app_done = 4'b0000; cycles(5);
    checks++; if (app_en !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL done_other: app_en=%b busy=%b, want 0100/1", app_en, busy); end
    app_done = 4'b0100; cycles(1);
    app_done = 4'b0000; cycles(1);
    checks++; if (app_en !== 4'b0000 || busy !== 1'b0 || led !== '0) begin errors++; $display("FAIL exit_state: app_en=%b busy=%b led=%h, want 0/0/0", app_en, busy, led); end
    cycles(1);
    checks++; if (led !== MENU2 || sel_idx !== 2'd2) begin errors++; $display("FAIL back_menu: led=%h sel=%0d, want %h/2", led, sel_idx, MENU2); end
  endtask

  task automatic test_escape();
    launch();
    keys = '0; cycles(12);
    checks++; if (app_en !== 4'b0100) begin errors++; $display("FAIL relaunch: app_en=%b, want 0100", app_en); end
    press(9'h100, 6);
    checks++; if (app_en !== 4'b0000 || busy !== 1'b0 || led !== MENU2) begin errors++; $display("FAIL escape: app_en=%b busy=%b led=%h, want 0/0/%h", app_en, busy, led, MENU2); end
    press(9'h003, 6);
    checks++; if (sel_idx !== 2'd2) begin errors++; $display("FAIL prev_next_same: sel_idx=%0d, want 2", sel_idx); end
  endtask

  task automatic test_reset_midrun();
    launch();
    keys = '0; cycles(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_rst_run: busy=%b, want 1", busy); end
    rst = 1'b1; cycles(1);
    checks++; if (app_en !== 4'b0000 || led !== '0 || sel_idx !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_run: app_en=%b led=%h sel=%0d busy=%b, want 0/0/0/0", app_en, led, sel_idx, busy); end
    rst = 1'b0; cycles(1);
    checks++; if (led !== MENU0) begin errors++; $display("FAIL rst_menu: led=%h, want %h", led, MENU0); end
  endtask

  initial begin
    for (int i = 0; i < NA*FW/32; i++) app_led[i*32 +: 32] = $urandom;
    test_reset();
    test_nav();
    test_launch();
    test_done();
    test_escape();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_app_dispatcher.md
Name: led_app_dispatcher

Overview:
Parametrised top-level dispatcher for the LED-matrix board, replacing the fixed menu/single-app wiring. It debounces the raw key inputs and runs a menu state machine that selects one of N_APPS application sub-modules. It hands the chosen sub-module a one-hot enable and the debounced keys, and muxes that sub-module's frame onto the LED matrix. Control returns to the menu on the app's done pulse or the global escape key.

Parameters:
ROWS, 16, LED matrix rows
COLS, 16, LED matrix columns
N_APPS, 4, number of application sub-modules (1..ROWS)
N_KEYS, 9, number of key inputs (>=4)
DEBOUNCE_CYC, 50000, cycles a key level must hold before it is accepted (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
keys  in  N_KEYS  raw key levels, 1 = pressed, asynchronous to clk
app_led  in  N_APPS*ROWS*COLS  app frames; app a occupies bits [a*ROWS*COLS +: ROWS*COLS]
app_done  in  N_APPS  per-app return request, 1-cycle pulse
app_en  out  N_APPS  one-hot enable of the running app
app_keys  out  N_KEYS  debounced key levels, forwarded only to the running app
led  out  ROWS*COLS  registered frame; bit index = row*COLS + col
sel_idx  out  clog2(N_APPS) (min 1)  currently highlighted/running app
busy  out  1  1 while any app is enabled

Behaviour:
- Key roles: keys[0] = prev, keys[1] = next, keys[2] = select, keys[N_KEYS-1] = escape. Other keys are app-only.
- Debounce, per key: 2-flop synchroniser, then a counter. The accepted level updates after DEBOUNCE_CYC consecutive cycles at the new synchronised level. Any bounce restarts the count.
- A press pulse (1 cycle) is generated on each accepted 0->1 transition.
- Reset:
  - state = MENU, sel_idx = 0.
  - app_en, app_keys, led, busy all 0.
  - Debounce accepted levels are 0 and counters are cleared.
- FSM states: MENU, LAUNCH, RUN, EXIT.
- MENU:
  - prev pulse: sel_idx decrements, wrapping 0 -> N_APPS-1.
  - next pulse: sel_idx increments, wrapping N_APPS-1 -> 0.
  - prev and next on the same cycle: no change.
  - select pulse: go to LAUNCH. Select has priority over prev/next on the same cycle, and sel_idx is not changed that cycle.
  - escape: ignored.
- LAUNCH (1 cycle): app_en = 1 << sel_idx, busy = 1, go to RUN.
- RUN:
  - app_en and busy stay asserted; app_keys = debounced levels.
  - app_done[sel_idx] pulse or escape pulse goes to EXIT.
  - app_done bits of non-running apps are ignored.
- EXIT (1 cycle): app_en = 0, app_keys = 0, busy = 0, go to MENU.
  - Key pulses arriving during EXIT are dropped.
  - app_done pulses arriving during LAUNCH are honoured on the next RUN cycle only if still asserted. Apps must not pulse done in their first enabled cycle.
- app_en, app_keys and busy are registered. app_en rises the cycle after the state enters LAUNCH.
- app_keys is 0 in every state other than LAUNCH/RUN, so apps never see menu navigation.
- led is registered, with 1-cycle latency from the state and inputs:
  - MENU: row sel_idx fully lit (COLS ones), plus col 0 lit in every row < N_APPS as an app marker; all other bits 0.
  - LAUNCH/RUN: the app_led slice of sel_idx.
  - EXIT: all zeros.
- Reset mid-RUN: app_en drops to 0 on the cycle after rst is sampled high, and sel_idx returns to 0.
- sel_idx never reaches a value >= N_APPS. With N_APPS = 1, prev/next leave it at 0.

Test Plan:
- Reset, then idle 10 cycles (ROWS=COLS=16, N_APPS=4, DEBOUNCE_CYC=4) -> sel_idx=0, app_en=0, led = row 0 all ones (bits 15:0) plus bits 16, 32, 48 set.
- Press next for 3 cycles with a 1-cycle glitch, then hold 10 -> exactly one increment, sel_idx=1. Press prev twice -> sel_idx=3 (wrap).
- With sel_idx=2, press select -> app_en=4'b0100 and busy=1; led equals app_led[2*256 +: 256] one cycle after LAUNCH; holding keys[5] gives app_keys[5]=1 after debounce.
- In RUN, pulse app_done[1] -> no change. Pulse app_done[2] -> EXIT then MENU, app_en=0, led shows row 2 lit.
- In RUN, press escape (keys[8]) -> return to MENU. Press prev+next together in MENU -> sel_idx unchanged.
- Assert rst for 1 cycle during RUN -> next cycle app_en=0, led=0, sel_idx=0, state MENU.
